// File: rtl/micropro_pipe_if.sv
// Instruction/result bus of the two-stage micro-processor pipe.
interface micropro_pipe_if #(
  parameter int XLEN = 32
);
  logic [31:0]     instr;
  logic            instr_valid;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic [4:0]      wb_rd;
  logic            invalid;

  // Instruction source side
  modport master (
    output instr, instr_valid,
    input  result, result_valid, wb_rd, invalid
  );

  // Pipeline side
  modport slave (
    input  instr, instr_valid,
    output result, result_valid, wb_rd, invalid
  );
endinterface

// File: rtl/micropro_pipe.sv
// Two-stage (ID -> EX/WB) R-type datapath with internal register file,
// EX->ID forwarding, hardwired-zero r0, index checking and optional MUL.
module micropro_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int EN_MUL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  micropro_pipe_if.slave     bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_MUL
  } op_e;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign opc = bus.instr[6:0];
  assign rd  = bus.instr[11:7];
  assign f3  = bus.instr[14:12];
  assign rs1 = bus.instr[19:15];
  assign rs2 = bus.instr[24:20];
  assign f7  = bus.instr[31:25];

  logic [XLEN-1:0] rf_q [NREGS];

  // [0]: legal op held in ID regs (EX this cycle); [1]: retired last edge
  logic [1:0]      vld_pipe_q;
  logic [1:0]      inv_pipe_q;
  op_e             op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] result_q;
  logic [4:0]      wb_rd_q;

  op_e             dec_op;
  logic            dec_ok, idx_ok, legal;
  logic [XLEN-1:0] rf_a, rf_b, a_d, b_d;
  logic [SHW-1:0]  shamt;

  // Opcode/funct3 decode; funct7 and indices are checked separately
  always_comb begin
    dec_op = OP_ADD;
    dec_ok = 1'b0;
    case (opc)
      7'b0000001: case (f3)
        3'b000: begin dec_op = OP_ADD; dec_ok = 1'b1; end
        3'b001: begin dec_op = OP_SUB; dec_ok = 1'b1; end
        default: ;
      endcase
      7'b0000011: case (f3)
        3'b000: begin dec_op = OP_SLL; dec_ok = 1'b1; end
        3'b001: begin dec_op = OP_SRL; dec_ok = 1'b1; end
        3'b010: begin dec_op = OP_SRA; dec_ok = 1'b1; end
        default: ;
      endcase
      7'b0000111: case (f3)
        3'b000: begin dec_op = OP_SLT;  dec_ok = 1'b1; end
        3'b001: begin dec_op = OP_SLTU; dec_ok = 1'b1; end
        default: ;
      endcase
      7'b0001111: case (f3)
        3'b000: begin dec_op = OP_XOR; dec_ok = 1'b1; end
        3'b001: begin dec_op = OP_OR;  dec_ok = 1'b1; end
        3'b010: begin dec_op = OP_AND; dec_ok = 1'b1; end
        default: ;
      endcase
      7'b0011111: if (f3 == 3'b000 && EN_MUL != 0) begin
        dec_op = OP_MUL; dec_ok = 1'b1;
      end
      default: ;
    endcase
  end

  assign idx_ok = ({1'b0, rs1} < 6'(NREGS)) && ({1'b0, rs2} < 6'(NREGS)) &&
                  ({1'b0, rd}  < 6'(NREGS));
  assign legal  = dec_ok && (f7 == 7'd0) && idx_ok;

  // Register-file read plus forwarding of the instruction now in EX
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rs1 == 5'(i)) rf_a = rf_q[i];
      if (rs2 == 5'(i)) rf_b = rf_q[i];
    end
    a_d = rf_a;
    b_d = rf_b;
    if (vld_pipe_q[0] && rd_q != 5'd0 && rd_q == rs1) a_d = alu_y;
    if (vld_pipe_q[0] && rd_q != 5'd0 && rd_q == rs2) b_d = alu_y;
  end

  // ID stage: latch decoded op and operands; rejected ops only raise a flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q[0] <= 1'b0;
      inv_pipe_q[0] <= 1'b0;
      op_q          <= OP_ADD;
      rd_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      vld_pipe_q[0] <= bus.instr_valid && legal;
      inv_pipe_q[0] <= bus.instr_valid && !legal;
      if (bus.instr_valid && legal) begin
        op_q <= dec_op;
        rd_q <= rd;
        a_q  <= a_d;
        b_q  <= b_d;
      end
    end
  end

  assign shamt = b_q[SHW-1:0];

  // ALU; everything wraps modulo 2^XLEN
  always_comb begin
    alu_y = '0;
    case (op_q)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_SLL:  alu_y = a_q << shamt;
      OP_SRL:  alu_y = a_q >> shamt;
      OP_SRA:  alu_y = $unsigned($signed(a_q) >>> shamt);
      OP_SLT:  alu_y = XLEN'($signed(a_q) < $signed(b_q));
      OP_SLTU: alu_y = XLEN'(a_q < b_q);
      OP_XOR:  alu_y = a_q ^ b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_MUL:  alu_y = a_q * b_q;
      default: alu_y = '0;
    endcase
  end

  // EX stage: retire pulse, result and destination hold until next retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q[1] <= 1'b0;
      inv_pipe_q[1] <= 1'b0;
      result_q      <= '0;
      wb_rd_q       <= '0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0];
      inv_pipe_q[1] <= inv_pipe_q[0];
      if (vld_pipe_q[0]) begin
        result_q <= alu_y;
        wb_rd_q  <= rd_q;
      end
    end
  end

  // Register file write-back; r0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= XLEN'(i);
    end else if (vld_pipe_q[0]) begin
      for (int i = 1; i < NREGS; i++)
        if (rd_q == 5'(i)) rf_q[i] <= alu_y;
    end
  end

  assign bus.result       = result_q;
  assign bus.result_valid = vld_pipe_q[1];
  assign bus.wb_rd        = wb_rd_q;
  assign bus.invalid      = inv_pipe_q[1];
endmodule

// File: tb/tb_micropro_pipe.sv
// Drives a 32-bit/32-reg/MUL pipe and an 8-bit/16-reg/no-MUL pipe with the
// same instruction stream and checks each against a sequential ISA model.
module tb_micropro_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  micropro_pipe_if #(.XLEN(32)) b0 ();
  micropro_pipe_if #(.XLEN(8))  b1 ();

  micropro_pipe #(.XLEN(32), .NREGS(32), .EN_MUL(1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  micropro_pipe #(.XLEN(8),  .NREGS(16), .EN_MUL(0)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_vec = 0;
  int n_err = 0;

  // model state, per DUT
  logic [63:0] m_r [2][32];
  logic [63:0] hold_res [2];
  logic [4:0]  hold_wb  [2];
  bit          pv [2];
  bit          pi [2];
  logic [63:0] p_res [2];
  logic [4:0]  p_rd  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [63:0] o_res(input int d);
    return (d == 0) ? 64'(b0.result) : 64'(b1.result);
  endfunction
  function automatic logic [63:0] o_rv(input int d);
    return (d == 0) ? 64'(b0.result_valid) : 64'(b1.result_valid);
  endfunction
  function automatic logic [63:0] o_inv(input int d);
    return (d == 0) ? 64'(b0.invalid) : 64'(b1.invalid);
  endfunction
  function automatic logic [63:0] o_wb(input int d);
    return (d == 0) ? 64'(b0.wb_rd) : 64'(b1.wb_rd);
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m_r[d][i] = (d == 0) ? 64'(i) : 64'(i % 256);
      hold_res[d] = '0; hold_wb[d] = '0;
      pv[d] = 0; pi[d] = 0; p_res[d] = '0; p_rd[d] = '0;
    end
  endtask

  // Architectural effect of one instruction, in program order
  task automatic mstep(input int d, input logic [31:0] ins, output bit ok, output logic [63:0] y);
    int xl, nr, sh, rs1, rs2, rd;
    bit em;
    logic [63:0] mask, a, b, sa, sb;
    logic [9:0] key;
    xl = (d == 0) ? 32 : 8;
    nr = (d == 0) ? 32 : 16;
    em = (d == 0);
    mask = (64'd1 << xl) - 64'd1;
    rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
    ok = (ins[31:25] == 7'd0) && rs1 < nr && rs2 < nr && rd < nr;
    a = (rs1 < nr) ? m_r[d][rs1] : 64'd0;
    b = (rs2 < nr) ? m_r[d][rs2] : 64'd0;
    sa = a[xl-1] ? (a | ~mask) : a;
    sb = b[xl-1] ? (b | ~mask) : b;
    sh = int'(b % 64'(xl));
    key = {ins[6:0], ins[14:12]};
    y = '0;
    case (key)
      10'b0000001_000: y = a + b;
      10'b0000001_001: y = a - b;
      10'b0000011_000: y = a << sh;
      10'b0000011_001: y = a >> sh;
      10'b0000011_010: y = $unsigned($signed(sa) >>> sh);
      10'b0000111_000: y = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      10'b0000111_001: y = (a < b) ? 64'd1 : 64'd0;
      10'b0001111_000: y = a ^ b;
      10'b0001111_001: y = a | b;
      10'b0001111_010: y = a & b;
      10'b0011111_000: if (em) y = a * b; else ok = 0;
      default: ok = 0;
    endcase
    y &= mask;
    if (ok && rd != 0) m_r[d][rd] = y;
  endtask

  // One cycle: present ins, then check what retired on this edge
  task automatic step(input bit v, input logic [31:0] ins);
    bit ok;
    logic [63:0] y;
    bit cv [2];
    bit ci [2];
    logic [63:0] cr [2];
    logic [4:0] cd [2];
    @(negedge clk);
    b0.instr = ins; b0.instr_valid = v;
    b1.instr = ins; b1.instr_valid = v;
    for (int d = 0; d < 2; d++) begin
      cv[d] = 0; ci[d] = 0; cr[d] = '0; cd[d] = ins[11:7];
      if (v) begin
        mstep(d, ins, ok, y);
        cv[d] = ok; ci[d] = !ok; cr[d] = y;
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      if (pv[d]) begin hold_res[d] = p_res[d]; hold_wb[d] = 64'(p_rd[d]); end
      chk($sformatf("d%0d_result_valid", d), o_rv(d), 64'(pv[d]));
      chk($sformatf("d%0d_invalid", d), o_inv(d), 64'(pi[d]));
      chk($sformatf("d%0d_result", d), o_res(d), hold_res[d]);
      chk($sformatf("d%0d_wb_rd", d), o_wb(d), 64'(hold_wb[d]));
      pv[d] = cv[d]; pi[d] = ci[d]; p_res[d] = cr[d]; p_rd[d] = cd[d];
    end
  endtask

  localparam logic [6:0] O_ADD = 7'b0000001, O_SH = 7'b0000011, O_SLT = 7'b0000111,
                         O_LOG = 7'b0001111, O_MUL = 7'b0011111;

  initial begin
    logic [31:0] ins;
    int r;
    b0.instr = '0; b0.instr_valid = 1'b0;
    b1.instr = '0; b1.instr_valid = 1'b0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_result", d), o_res(d), 64'd0);
      chk($sformatf("d%0d_rst_rv", d), o_rv(d), 64'd0);
      chk($sformatf("d%0d_rst_wb", d), o_wb(d), 64'd0);
      chk($sformatf("d%0d_rst_inv", d), o_inv(d), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // directed program
    step(1, enc(0, 1, 0, 3'd0, 8, O_ADD));       // r8 = r0 + r1
    step(0, '0);
    chk("add_r8", o_res(0), 64'd1);
    chk("add_r8_wb", o_wb(0), 64'd8);
    step(1, enc(0, 1, 0, 3'd1, 9, O_ADD));       // r9 = r0 - r1
    step(1, enc(0, 3, 9, 3'd2, 14, O_SH));       // r14 = r9 >>> r3
    step(1, enc(0, 3, 9, 3'd1, 15, O_SH));       // r15 = r9 >> r3
    chk("sra", o_res(0), 64'hFFFF_FFFF);
    step(0, '0);
    chk("srl", o_res(0), 64'h1FFF_FFFF);
    step(1, enc(0, 3, 2, 3'd0, 10, O_SH));       // r10 = r2 << r3
    step(1, enc(0, 1, 10, 3'd0, 11, O_ADD));     // r11 = r10 + r1 (forwarded)
    chk("sll", o_res(0), 64'd16);
    step(0, '0);
    chk("fwd_add", o_res(0), 64'd17);
    step(1, enc(0, 1, 9, 3'd0, 12, O_SLT));
    step(1, enc(0, 1, 9, 3'd1, 13, O_SLT));
    step(1, enc(0, 5, 4, 3'd0, 12, O_SLT));
    step(1, enc(0, 6, 5, 3'd0, 16, O_MUL));      // r16 = r5 * r6
    step(0, '0);
    chk("mul", o_res(0), 64'd30);
    chk("mul_inv_d1", o_inv(1), 64'd1);
    step(1, enc(7'd1, 1, 0, 3'd0, 8, O_ADD));    // bad funct7
    step(1, enc(0, 1, 1, 3'd0, 0, O_ADD));       // rd = r0
    chk("bad_f7_inv", o_inv(0), 64'd1);
    chk("bad_f7_hold", o_res(0), 64'd30);
    step(1, enc(0, 0, 0, 3'd0, 17, O_ADD));      // r17 = r0 + r0
    step(1, enc(0, 1, 0, 3'd0, 16, O_ADD));      // rd16: illegal on 16-reg pipe
    chk("r0_stays0", o_res(0), 64'd0);
    step(1, enc(0, 1, 0, 3'd1, 5, O_ADD));       // r5 = r0 - r1
    chk("rd16_inv_d1", o_inv(1), 64'd1);
    step(1, enc(0, 1, 5, 3'd0, 6, O_ADD));       // r6 = r5 + r1
    chk("all_ones_d1", o_res(1), 64'hFF);
    step(0, '0);
    chk("wrap_d1", o_res(1), 64'd0);

    // reset between two back-to-back instructions
    step(1, enc(0, 1, 1, 3'd0, 8, O_ADD));
    @(negedge clk);
    b0.instr = enc(0, 2, 2, 3'd0, 8, O_ADD); b0.instr_valid = 1'b1;
    b1.instr = enc(0, 2, 2, 3'd0, 8, O_ADD); b1.instr_valid = 1'b1;
    rst_n = 1'b0;
    mreset();
    @(posedge clk); #1;
    chk("midrst_rv0", o_rv(0), 64'd0);
    chk("midrst_rv1", o_rv(1), 64'd0);
    @(negedge clk);
    b0.instr_valid = 1'b0; b1.instr_valid = 1'b0;
    rst_n = 1'b1;
    step(0, '0);
    chk("midrst_rv0_b", o_rv(0), 64'd0);
    step(1, enc(0, 0, 8, 3'd0, 9, O_ADD));       // r9 = r8 + r0
    step(0, '0);
    chk("r8_after_rst", o_res(0), 64'd8);

    // randomized stream
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 10))
        0:  ins = enc(0, 0, 0, 3'd0, 0, O_ADD);
        1:  ins = enc(0, 0, 0, 3'd1, 0, O_ADD);
        2:  ins = enc(0, 0, 0, 3'd0, 0, O_SH);
        3:  ins = enc(0, 0, 0, 3'd1, 0, O_SH);
        4:  ins = enc(0, 0, 0, 3'd2, 0, O_SH);
        5:  ins = enc(0, 0, 0, 3'd0, 0, O_SLT);
        6:  ins = enc(0, 0, 0, 3'd1, 0, O_SLT);
        7:  ins = enc(0, 0, 0, 3'd0, 0, O_LOG);
        8:  ins = enc(0, 0, 0, 3'd1, 0, O_LOG);
        9:  ins = enc(0, 0, 0, 3'd2, 0, O_LOG);
        default: ins = enc(0, 0, 0, 3'd0, 0, O_MUL);
      endcase
      ins[11:7]  = 5'($urandom_range(0, 19));
      ins[19:15] = 5'($urandom_range(0, 19));
      ins[24:20] = 5'($urandom_range(0, 19));
      if (r < 4) ins[31:25] = 7'($urandom_range(1, 127));
      else if (r < 8) ins[14:12] = 3'($urandom_range(0, 7));
      else if (r < 10) ins[6:0] = 7'($urandom);
      step(r >= 85 ? 1'b0 : 1'b1, ins);
    end
    step(0, '0);
    step(0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
